// File: rtl/adder_frame_acc.sv
// Frame accumulator for the adder sum stream: sums FRAME_LEN valid samples with
// saturation and queues completed frame totals in a FWFT FIFO with drop counting.
module adder_frame_acc #(
  parameter int unsigned DATA_W     = 9,
  parameter int unsigned ACC_W      = 16,
  parameter int unsigned FRAME_LEN  = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] c_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf,
  output logic [7:0]        drop_cnt
);

  localparam int unsigned CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic             ovf;
    logic [ACC_W-1:0] sum;
  } frame_t;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [7:0]       drop_q, drop_d;
  logic             out_valid_q, out_valid_d;
  frame_t           mem_q [FIFO_DEPTH];

  logic [ACC_W:0]   sum_ext;
  logic             sat;
  frame_t           result;
  logic             frame_done;
  logic             pop;
  logic             push;

  // Circular pointer increment; wraps at FIFO_DEPTH so non-power-of-2 depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    drop_d      = drop_q;

    // Extra bit catches the carry; a sticky overflow keeps the frame pinned at max.
    sum_ext     = {1'b0, acc_q} + (ACC_W + 1)'(c_in);
    sat         = sum_ext[ACC_W] | ovf_q;
    result.ovf  = sat;
    result.sum  = sat ? '1 : sum_ext[ACC_W-1:0];

    frame_done  = valid_in && (cnt_q == CNT_W'(FRAME_LEN - 1));
    pop         = out_valid_q && out_ready;
    push        = frame_done && ((occ_q != OCC_W'(FIFO_DEPTH)) || pop);

    if (valid_in) begin
      if (frame_done) begin
        acc_d = '0;
        cnt_d = '0;
        ovf_d = 1'b0;
      end else begin
        acc_d = result.sum;
        cnt_d = cnt_q + CNT_W'(1);
        ovf_d = sat;
      end
    end

    if (frame_done && !push && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end

    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    occ_d       = occ_q + OCC_W'(push) - OCC_W'(pop);
    out_valid_d = (occ_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      drop_q      <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      drop_q      <= drop_d;
      out_valid_q <= out_valid_d;
      if (push) begin
        mem_q[wr_ptr_q] <= result;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = mem_q[rd_ptr_q].sum;
  assign out_ovf   = mem_q[rd_ptr_q].ovf;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_adder_frame_acc.sv
// Scoreboard bench for adder_frame_acc: a frame model queues expected totals as
// samples are driven; the FIFO head is compared each cycle on the falling edge.
module tb_adder_frame_acc;

  localparam int unsigned DATA_W     = 9;
  localparam int unsigned ACC_W      = 10;
  localparam int unsigned FRAME_LEN  = 4;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int          MAXV       = (1 << ACC_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              valid_in;
  logic [DATA_W-1:0] c_in;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_ovf;
  logic [7:0]        drop_cnt;

  adder_frame_acc #(
    .DATA_W    (DATA_W),
    .ACC_W     (ACC_W),
    .FRAME_LEN (FRAME_LEN),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_in (valid_in),
    .c_in     (c_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_ovf  (out_ovf),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sum;
    bit ovf;
  } tb_frame_t;

  tb_frame_t exp_q [$];
  int        got_q [$];
  int        m_acc;
  int        m_cnt;
  bit        m_ovf;
  int        m_drop;
  int        checks = 0;
  int        errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_acc  = 0;
    m_cnt  = 0;
    m_ovf  = 0;
    m_drop = 0;
    exp_q.delete();
    got_q.delete();
  endtask

  // Reference behaviour for one rising edge with the given inputs.
  task automatic model_edge(input logic v, input int c, input logic rdy);
    int        nx;
    bit        o;
    tb_frame_t f;
    if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
    if (v) begin
      nx    = m_acc + c;
      o     = m_ovf || (nx > MAXV);
      f.sum = o ? MAXV : nx;
      f.ovf = o;
      if (m_cnt == int'(FRAME_LEN) - 1) begin
        if (exp_q.size() < int'(FIFO_DEPTH)) exp_q.push_back(f);
        else if (m_drop < 255) m_drop++;
        m_acc = 0;
        m_cnt = 0;
        m_ovf = 0;
      end else begin
        m_acc = f.sum;
        m_cnt++;
        m_ovf = o;
      end
    end
  endtask

  task automatic compare();
    check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("out_sum", 32'(out_sum), 32'(exp_q[0].sum));
      check("out_ovf", 32'(out_ovf), 32'(exp_q[0].ovf));
    end
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
  endtask

  // Drive one cycle from a falling edge, advance, and compare on the next falling edge.
  task automatic step(input logic v, input int c, input logic rdy);
    valid_in  = v;
    c_in      = DATA_W'(c);
    out_ready = rdy;
    if (out_valid && out_ready) got_q.push_back(int'(out_sum));
    model_edge(v, c, rdy);
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic frame4(input int val, input logic rdy_rest, input logic rdy_last);
    for (int i = 0; i < 3; i++) step(1'b1, val, rdy_rest);
    step(1'b1, val, rdy_last);
  endtask

  task automatic check_got(input string tag, input int e[$]);
    check({tag, "_count"}, 32'(got_q.size()), 32'(e.size()));
    for (int i = 0; i < e.size() && i < got_q.size(); i++) begin
      check(tag, 32'(got_q[i]), 32'(e[i]));
    end
    got_q.delete();
  endtask

  initial begin
    int e[$];
    int n;

    rst_n     = 1'b0;
    valid_in  = 1'b0;
    c_in      = '0;
    out_ready = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_sum", 32'(out_sum), 0);
    check("rst_ovf", 32'(out_ovf), 0);
    check("rst_drop", 32'(drop_cnt), 0);
    rst_n = 1'b1;

    // Basic frame with a single-cycle head.
    step(1'b1, 10, 1'b1);
    step(1'b1, 20, 1'b1);
    step(1'b1, 30, 1'b1);
    check("basic_not_yet", 32'(out_valid), 0);
    step(1'b1, 40, 1'b1);
    check("basic_valid", 32'(out_valid), 1);
    step(1'b0, 0, 1'b1);
    check("basic_one_cycle", 32'(out_valid), 0);
    e = '{100};
    check_got("basic", e);

    // Idle gaps neither add nor advance the sample count.
    step(1'b1, 1, 1'b1);
    step(1'b0, 99, 1'b1);
    step(1'b1, 2, 1'b1);
    step(1'b0, 77, 1'b1);
    step(1'b0, 55, 1'b1);
    step(1'b1, 3, 1'b1);
    step(1'b1, 4, 1'b1);
    step(1'b0, 0, 1'b1);
    e = '{10};
    check_got("gaps", e);

    // Saturation, then flag cleared on the next frame.
    frame4(510, 1'b1, 1'b1);
    check("sat_ovf", 32'(out_ovf), 1);
    check("sat_sum", 32'(out_sum), 1023);
    step(1'b0, 0, 1'b1);
    frame4(1, 1'b1, 1'b1);
    check("post_sat_ovf", 32'(out_ovf), 0);
    step(1'b0, 0, 1'b1);
    e = '{1023, 4};
    check_got("sat", e);

    // Backpressure fills the FIFO; the fifth frame is dropped.
    for (int k = 1; k <= 5; k++) frame4(k, 1'b0, 1'b0);
    check("bp_drop", 32'(drop_cnt), 1);
    for (int i = 0; i < 5; i++) step(1'b0, 0, 1'b1);
    check("bp_empty", 32'(out_valid), 0);
    e = '{4, 8, 12, 16};
    check_got("bp", e);

    // Full FIFO with a pop on the completing edge accepts the new frame.
    for (int k = 1; k <= 4; k++) frame4(k, 1'b0, 1'b0);
    frame4(5, 1'b0, 1'b1);
    check("full_pop_drop", 32'(drop_cnt), 1);
    for (int i = 0; i < 5; i++) step(1'b0, 0, 1'b1);
    e = '{4, 8, 12, 16, 20};
    check_got("full_pop", e);

    // Reset mid-frame discards the partial frame and queued frames.
    frame4(1, 1'b0, 1'b0);
    step(1'b1, 5, 1'b0);
    step(1'b1, 6, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_sum", 32'(out_sum), 0);
    check("mid_rst_ovf", 32'(out_ovf), 0);
    check("mid_rst_drop", 32'(drop_cnt), 0);
    model_clear();
    #2;
    rst_n = 1'b1;
    step(1'b1, 1, 1'b1);
    step(1'b1, 2, 1'b1);
    step(1'b1, 3, 1'b1);
    step(1'b1, 4, 1'b1);
    step(1'b0, 0, 1'b1);
    e = '{10};
    check_got("after_rst", e);

    // Random traffic against the model, then a bounded drain.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 300)),
           1'($urandom_range(0, 2) == 0));
    end
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      step(1'b0, 0, 1'b1);
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
